// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: writeback stage of the 5-stage RISC-V pipeline.
//   Formats the raw load word, selects the writeback result and commits it to
//   the 32 x XLEN integer register file. It also serves the two decode-stage
//   read ports with a write-through bypass.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   reg_write_w              W-stage register-write enable
//   result_src_w[1:0]        00 ALU, 01 load, 10 PC+4, 11 immediate
//   funct3_w[2:0]            load size/sign code
//   rd_w[4:0]                destination register index
//   alu_result_w             ALU result / effective address
//   read_data_w              raw memory word
//   pc_plus4_w               PC+4 (jal/jalr)
//   ext_imm_w                extended immediate (lui)
//   rs1_d, rs2_d             decode read indices
//   rd1_d, rd2_d             decode read data
//   result_w                 selected writeback value (also to forwarding unit)
module wb_regfile_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write_w,
  input  logic [1:0]               result_src_w,
  input  logic [2:0]               funct3_w,
  input  logic [$clog2(NREGS)-1:0] rd_w,
  input  logic [XLEN-1:0]          alu_result_w,
  input  logic [XLEN-1:0]          read_data_w,
  input  logic [XLEN-1:0]          pc_plus4_w,
  input  logic [XLEN-1:0]          ext_imm_w,
  input  logic [$clog2(NREGS)-1:0] rs1_d,
  input  logic [$clog2(NREGS)-1:0] rs2_d,
  output logic [XLEN-1:0]          rd1_d,
  output logic [XLEN-1:0]          rd2_d,
  output logic [XLEN-1:0]          result_w
);

  localparam int IDX_W = $clog2(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_result;
  logic            w_wr_en;

  // Load formatting. Misaligned accesses are not trapped: the halfword lane
  // is chosen by address bit 1 alone.
  function automatic logic [XLEN-1:0] f_fmt_load(input logic [2:0]      f3,
                                                 input logic [1:0]      off,
                                                 input logic [XLEN-1:0] word);
    logic [XLEN-1:0] v_bsh;
    logic [XLEN-1:0] v_hsh;
    logic [7:0]      v_b;
    logic [15:0]     v_h;
    v_bsh = word >> {off, 3'b000};
    v_hsh = word >> {off[1], 4'b0000};
    v_b   = v_bsh[7:0];
    v_h   = v_hsh[15:0];
    case (f3)
      3'b000:  f_fmt_load = {{(XLEN-8){v_b[7]}}, v_b};
      3'b100:  f_fmt_load = {{(XLEN-8){1'b0}}, v_b};
      3'b001:  f_fmt_load = {{(XLEN-16){v_h[15]}}, v_h};
      3'b101:  f_fmt_load = {{(XLEN-16){1'b0}}, v_h};
      default: f_fmt_load = word;
    endcase
  endfunction

  assign w_load = f_fmt_load(funct3_w, alu_result_w[1:0], read_data_w);

  always_comb begin
    w_result = alu_result_w;
    case (result_src_w)
      2'b00:   w_result = alu_result_w;
      2'b01:   w_result = w_load;
      2'b10:   w_result = pc_plus4_w;
      default: w_result = ext_imm_w;
    endcase
  end

  assign result_w = w_result;

  // x0 is never written, so it keeps its reset value of zero.
  assign w_wr_en = reg_write_w && (rd_w != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[rd_w] <= w_result;
    end
  end

  // Write-through read: a write in flight this cycle is visible immediately,
  // so decode never stalls on a W-stage producer. Reset forces zero.
  function automatic logic [XLEN-1:0] f_read(input logic [IDX_W-1:0] idx,
                                             input logic             in_rst,
                                             input logic             wr_en,
                                             input logic [IDX_W-1:0] wr_idx,
                                             input logic [XLEN-1:0]  wr_data,
                                             input logic [XLEN-1:0]  stored);
    if (in_rst || idx == '0)            f_read = '0;
    else if (wr_en && wr_idx == idx)    f_read = wr_data;
    else                                f_read = stored;
  endfunction

  assign rd1_d = f_read(rs1_d, rst, w_wr_en, rd_w, w_result, r_regs[rs1_d]);
  assign rd2_d = f_read(rs2_d, rst, w_wr_en, rd_w, w_result, r_regs[rs2_d]);

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Writeback stage of the 5-stage pipelined RISC-V core; sits directly downstream of the MEM/WB pipeline register.
- Takes the registered W-stage bundle, formats load data, and selects the writeback result.
- Commits the result to the 32x32 integer register file.
- Serves the two decode-stage read ports with write-through bypass, so a same-cycle write/read needs no extra hazard stall.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, number of architectural registers; index width is 5.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- reg_write_w  input  1  W-stage register-write enable
- result_src_w  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate
- funct3_w  input  3  load size/sign code
- rd_w  input  5  destination register index
- alu_result_w  input  32  ALU result / effective address
- read_data_w  input  32  raw memory word
- pc_plus4_w  input  32  PC+4, for jal/jalr
- ext_imm_w  input  32  extended immediate, for lui
- rs1_d  input  5  decode read index A
- rs2_d  input  5  decode read index B
- rd1_d  output  32  read data A
- rd2_d  output  32  read data B
- result_w  output  32  selected writeback value, also used by the forwarding unit

Behaviour:
- Reset:
  - rst=1 asynchronously clears all 32 registers to 0.
  - While rst=1, writes are blocked and rd1_d/rd2_d read 0.
  - Reset asserted mid-operation discards any write due at that edge.
- Load formatting (combinational):
  - Byte offset = alu_result_w[1:0].
  - funct3 000 lb: byte at offset, sign-extended.
  - funct3 100 lbu: byte at offset, zero-extended.
  - funct3 001 lh: halfword at alu_result_w[1]*16, sign-extended.
  - funct3 101 lhu: same halfword, zero-extended.
  - funct3 010 lw, and any other code: full word; offset ignored.
  - Misalignment is not trapped here; the halfword select uses bit 1 only.
- Result select (combinational): result_w = mux(result_src_w) over alu_result_w, formatted load, pc_plus4_w, ext_imm_w. result_w is valid even when reg_write_w=0.
- Write:
  - On rising clk, if reg_write_w=1 and rd_w!=0, then regs[rd_w] <= result_w.
  - x0 is never written and always reads 0.
  - Write latency is 1 edge.
- Read:
  - Combinational, zero latency.
  - rd1_d = 0 if rs1_d==0.
  - Else rd1_d = result_w if reg_write_w && rd_w==rs1_d && rd_w!=0 (write-through bypass).
  - Else rd1_d = regs[rs1_d].
  - rd2_d follows the same rules using rs2_d.
- Simultaneous events:
  - Both read ports may hit the same register and the bypass in the same cycle; both see result_w.
  - Back-to-back writes to the same rd: the last edge wins.
- No internal state besides the register array; no stall or flush inputs. Bubbles arrive as reg_write_w=0.

Test Plan:
- Reset: preload x5=0x1234 → assert rst between edges → rd1_d(rs1=5)=0 immediately, no clk edge needed. After release, x5 stays 0 until written.
- ALU write + bypass: reg_write=1, src=00, rd=7, alu=0xDEADBEEF, rs1=rs2=7 → rd1_d=rd2_d=0xDEADBEEF the same cycle. After the edge with reg_write=0 → still 0xDEADBEEF.
- Loads, read_data=0x80F17F82:
  - lb off0 → 0xFFFFFF82
  - lbu off0 → 0x00000082
  - lb off1 → 0x0000007F
  - lh off2 → 0xFFFF80F1
  - lhu off2 → 0x000080F1
  - lw off3 → 0x80F17F82
- x0 protection: reg_write=1, rd=0, alu=0xFFFFFFFF, rs1=0 → rd1_d=0 before and after the edge; result_w=0xFFFFFFFF.
- jal/lui: src=10, pc_plus4=0x00000104, rd=1 → x1=0x104. Then src=11, ext_imm=0xABCDE000, rd=2 → x2=0xABCDE000. reg_write=0 with rd=3 → x3 unchanged.
